// File: rtl/blood_pkg.sv
// Shared types and compatibility rules for the blood-compatibility datapath.
//   abo_e     : 2-bit ABO group, encoded {a,b}: 00=O, 01=B, 10=A, 11=AB.
//   donor_t   : one registry entry {a, b, rh, vld}.
//   patient_t : latched patient request {a, b, rh}.
//   state_e   : donor_finder FSM states.
//   is_compat : donor antigens must be a subset of the patient's antigens.
//   is_exact  : compatible and same ABO group and Rh as the patient.
package blood_pkg;

  typedef enum logic [1:0] {
    ABO_O  = 2'b00,
    ABO_B  = 2'b01,
    ABO_A  = 2'b10,
    ABO_AB = 2'b11
  } abo_e;

  typedef struct packed {
    logic a;
    logic b;
    logic rh;
    logic vld;
  } donor_t;

  typedef struct packed {
    logic a;
    logic b;
    logic rh;
  } patient_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic abo_e abo_of(input logic a, input logic b);
    return abo_e'({a, b});
  endfunction

  function automatic logic is_compat(input donor_t d, input patient_t p);
    return d.vld && (!d.a || p.a) && (!d.b || p.b) && (!d.rh || p.rh);
  endfunction

  function automatic logic is_exact(input donor_t d, input patient_t p);
    return is_compat(d, p) && (abo_of(d.a, d.b) == abo_of(p.a, p.b)) && (d.rh == p.rh);
  endfunction

endpackage

// File: rtl/blood_compat.sv
// Combinational compatibility evaluator for a single donor entry.
//   donor_i   : registry entry selected by the scan pointer.
//   patient_i : latched patient request.
//   compat_o  : entry is valid and compatible with the patient.
//   exact_o   : entry is compatible and matches ABO group and Rh exactly.
module blood_compat
  import blood_pkg::*;
(
  input  donor_t   donor_i,
  input  patient_t patient_i,
  output logic     compat_o,
  output logic     exact_o
);

  assign compat_o = is_compat(donor_i, patient_i);
  assign exact_o  = is_exact(donor_i, patient_i);

endmodule

// File: rtl/donor_finder.sv
// Patient-side donor search engine.
// Holds a flop-based registry of DEPTH donor entries, accepts a patient
// request and scans one entry per clock, then reports the best donor.
//   clk, rst             : clock, asynchronous active-high reset.
//   wr_en/wr_idx/wr_a/wr_b/wr_rh/wr_vld : registry write port (any state).
//   req_valid/req_ready  : request handshake; req_a/req_b/req_rh patient,
//                          req_take clears the chosen entry on a found result.
//   rsp_valid/rsp_ready  : response handshake; rsp_found, rsp_exact,
//                          rsp_idx (chosen entry), rsp_count (compatible count).
//   dbg_state            : current FSM state (state_e encoding).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. rsp_valid, once high, stays high with all rsp_* fields stable
// until the transfer; req_ready is high only in IDLE.
module donor_finder
  import blood_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_a,
  input  logic             wr_b,
  input  logic             wr_rh,
  input  logic             wr_vld,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             req_rh,
  input  logic             req_take,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_found,
  output logic             rsp_exact,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [IDX_W:0]   rsp_count,
  output logic [1:0]       dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] fc_idx_q, fc_idx_d;   // first compatible index
  logic             fc_vld_q, fc_vld_d;
  logic [IDX_W-1:0] fe_idx_q, fe_idx_d;   // first exact index
  logic             fe_vld_q, fe_vld_d;
  patient_t         pat_q, pat_d;
  logic             take_q, take_d;
  logic             take_clr;

  donor_t           reg_q [DEPTH];
  logic             cur_compat;
  logic             cur_exact;

  // The entry under evaluation is read straight from the flops, so a write
  // landing on it this cycle only takes effect after it has been evaluated.
  blood_compat u_compat (
    .donor_i   (reg_q[ptr_q]),
    .patient_i (pat_q),
    .compat_o  (cur_compat),
    .exact_o   (cur_exact)
  );

  // Response fields come straight from the scan accumulators, which are
  // frozen while in RESP. With nothing found both index registers are 0.
  assign rsp_found = fc_vld_q;
  assign rsp_exact = fe_vld_q;
  assign rsp_idx   = fe_vld_q ? fe_idx_q : fc_idx_q;
  assign rsp_count = cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    fc_idx_d  = fc_idx_q;
    fc_vld_d  = fc_vld_q;
    fe_idx_d  = fe_idx_q;
    fe_vld_d  = fe_vld_q;
    pat_d     = pat_q;
    take_d    = take_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    take_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pat_d    = '{a: req_a, b: req_b, rh: req_rh};
          take_d   = req_take;
          cnt_d    = '0;
          fc_idx_d = '0;
          fc_vld_d = 1'b0;
          fe_idx_d = '0;
          fe_vld_d = 1'b0;
          ptr_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cur_compat) begin
          cnt_d = cnt_q + (IDX_W + 1)'(1);
          if (!fc_vld_q) begin
            fc_vld_d = 1'b1;
            fc_idx_d = ptr_q;
          end
        end
        if (cur_exact && !fe_vld_q) begin
          fe_vld_d = 1'b1;
          fe_idx_d = ptr_q;
        end
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) begin
          ptr_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          take_clr = fc_vld_q && take_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      fc_idx_q <= '0;
      fc_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_vld_q <= 1'b0;
      pat_q    <= '0;
      take_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      fc_idx_q <= fc_idx_d;
      fc_vld_q <= fc_vld_d;
      fe_idx_q <= fe_idx_d;
      fe_vld_q <= fe_vld_d;
      pat_q    <= pat_d;
      take_q   <= take_d;
    end
  end

  // Registry: a write to the same entry as a take wins and keeps wr_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) reg_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          reg_q[i] <= '{a: wr_a, b: wr_b, rh: wr_rh, vld: wr_vld};
        end else if (take_clr && (rsp_idx == IDX_W'(i))) begin
          reg_q[i].vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_donor_finder.sv
// Self-checking bench for donor_finder: directed scenarios followed by
// randomized requests, all compared against a behavioural registry model.
module tb_donor_finder;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int EW    = 2 + IDX_W + IDX_W + 1;  // {found, exact, idx, count}

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_a, wr_b, wr_rh, wr_vld;
  logic             req_valid, req_ready;
  logic             req_a, req_b, req_rh, req_take;
  logic             rsp_valid, rsp_ready;
  logic             rsp_found, rsp_exact;
  logic [IDX_W-1:0] rsp_idx;
  logic [IDX_W:0]   rsp_count;
  logic [1:0]       dbg_state;

  donor_finder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .wr_rh     (wr_rh),
    .wr_vld    (wr_vld),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rh    (req_rh),
    .req_take  (req_take),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_found (rsp_found),
    .rsp_exact (rsp_exact),
    .rsp_idx   (rsp_idx),
    .rsp_count (rsp_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model and scoreboard ----------------
  typedef struct packed {
    logic a;
    logic b;
    logic rh;
    logic vld;
  } ent_t;

  ent_t            model [DEPTH];   // registry as it currently stands
  ent_t            view  [DEPTH];   // registry as the running scan sees it
  logic [EW-1:0]   exp_q [$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic            last_found, last_exact;
  int              last_idx, last_count;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // A donor is compatible when its antigen set {A,B,Rh} is a subset of the
  // patient's; exact when the sets are equal. Lowest index wins.
  function automatic logic [EW-1:0] ref_search(input logic pa, input logic pb, input logic prh);
    int         cnt;
    int         fc;
    int         fe;
    logic [2:0] pat;
    logic [2:0] don;
    cnt = 0;
    fc  = -1;
    fe  = -1;
    pat = {pa, pb, prh};
    for (int i = 0; i < DEPTH; i++) begin
      don = {view[i].a, view[i].b, view[i].rh};
      if (view[i].vld && ((don & ~pat) == 3'b000)) begin
        cnt++;
        if (fc < 0) fc = i;
        if (don == pat && fe < 0) fe = i;
      end
    end
    if (fe >= 0) return {1'b1, 1'b1, IDX_W'(fe), (IDX_W + 1)'(cnt)};
    if (fc >= 0) return {1'b1, 1'b0, IDX_W'(fc), (IDX_W + 1)'(cnt)};
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reg_write(input int idx, input logic a, input logic b, input logic rh, input logic v);
    wr_en  = 1'b1;
    wr_idx = IDX_W'(idx);
    wr_a   = a;
    wr_b   = b;
    wr_rh  = rh;
    wr_vld = v;
    model[idx] = '{a: a, b: b, rh: rh, vld: v};
    step();
    wr_en = 1'b0;
  endtask

  // One full request. wk >= 0 drives a registry write (entry wj) while the
  // scan pointer sits at wk. hold = cycles rsp_ready stays low in RESP.
  // collide drives a wr_vld=1 write to the chosen entry on the handshake.
  task automatic run_request(input logic pa, input logic pb, input logic prh, input logic take,
                             input int wk, input int wj, input logic wa, input logic wb,
                             input logic wrh, input logic wv, input int hold, input logic collide);
    logic [EW-1:0] e;
    logic          ca, cb, crh;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = pa;
    req_b     = pb;
    req_rh    = prh;
    req_take  = take;
    step();
    req_valid = 1'b0;
    req_take  = 1'($urandom_range(0, 1));
    view = model;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) check("req_ready_busy", req_ready, 0);
      if (k == 0 || k == DEPTH - 1) check("rsp_valid_scan", rsp_valid, 0);
      if (k == wk) begin
        wr_en  = 1'b1;
        wr_idx = IDX_W'(wj);
        wr_a   = wa;
        wr_b   = wb;
        wr_rh  = wrh;
        wr_vld = wv;
        model[wj] = '{a: wa, b: wb, rh: wrh, vld: wv};
        if (wj > k) view[wj] = model[wj];
      end
      step();
      wr_en = 1'b0;
    end
    exp_q.push_back(ref_search(pa, pb, prh));
    check("rsp_valid_latency", rsp_valid, 1);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_idx", rsp_idx, int'(exp_q[0][IDX_W + IDX_W:IDX_W + 1]));
      check("hold_count", rsp_count, int'(exp_q[0][IDX_W:0]));
      step();
    end
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_found", rsp_found, int'(e[EW-1]));
    check("rsp_exact", rsp_exact, int'(e[EW-2]));
    check("rsp_idx", rsp_idx, int'(e[IDX_W + IDX_W:IDX_W + 1]));
    check("rsp_count", rsp_count, int'(e[IDX_W:0]));
    last_found = rsp_found;
    last_exact = rsp_exact;
    last_idx   = int'(rsp_idx);
    last_count = int'(rsp_count);
    rsp_ready = 1'b1;
    if (collide && e[EW-1]) begin
      ca  = 1'($urandom_range(0, 1));
      cb  = 1'($urandom_range(0, 1));
      crh = 1'($urandom_range(0, 1));
      wr_en  = 1'b1;
      wr_idx = e[IDX_W + IDX_W:IDX_W + 1];
      wr_a   = ca;
      wr_b   = cb;
      wr_rh  = crh;
      wr_vld = 1'b1;
      model[int'(e[IDX_W + IDX_W:IDX_W + 1])] = '{a: ca, b: cb, rh: crh, vld: 1'b1};
    end else if (e[EW-1] && take) begin
      model[int'(e[IDX_W + IDX_W:IDX_W + 1])].vld = 1'b0;
    end
    step();
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  task automatic simple_request(input logic pa, input logic pb, input logic prh, input logic take);
    run_request(pa, pb, prh, take, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Reset asserted while the scan pointer is at k.
  task automatic abort_at(input int k);
    req_valid = 1'b1;
    req_a     = 1'b1;
    req_b     = 1'b1;
    req_rh    = 1'b1;
    req_take  = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (k) step();
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    for (int i = 0; i < DEPTH; i++) model[i].vld = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      if (rsp_valid !== 1'b0) check("abort_no_rsp", rsp_valid, 0);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_rh     = 1'b0;
    wr_vld    = 1'b0;
    req_valid = 1'b0;
    req_a     = 1'b0;
    req_b     = 1'b0;
    req_rh    = 1'b0;
    req_take  = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step();
    step();
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_found", rsp_found, 0);
    check("reset_rsp_exact", rsp_exact, 0);
    check("reset_rsp_idx", rsp_idx, 0);
    check("reset_rsp_count", rsp_count, 0);
    rst = 1'b0;
    step();

    // 1: empty registry, patient AB+
    simple_request(1'b1, 1'b1, 1'b1, 1'b0);
    check("tp1_found", last_found, 0);
    check("tp1_count", last_count, 0);

    // 2: O-, A+, A+ ; patient A+
    reg_write(3, 1'b0, 1'b0, 1'b0, 1'b1);
    reg_write(7, 1'b1, 1'b0, 1'b1, 1'b1);
    reg_write(9, 1'b1, 1'b0, 1'b1, 1'b1);
    simple_request(1'b1, 1'b0, 1'b1, 1'b0);
    check("tp2_idx", last_idx, 7);
    check("tp2_exact", last_exact, 1);
    check("tp2_count", last_count, 3);

    // 3: only B+ at 2 and O- at 5
    reg_write(3, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(7, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(9, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(2, 1'b0, 1'b1, 1'b1, 1'b1);
    reg_write(5, 1'b0, 1'b0, 1'b0, 1'b1);
    simple_request(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp3_found", last_found, 1);
    check("tp3_idx", last_idx, 5);
    check("tp3_count", last_count, 1);
    simple_request(1'b1, 1'b0, 1'b0, 1'b0);
    check("tp3b_idx", last_idx, 5);
    check("tp3b_exact", last_exact, 0);

    // 4: take the only O- unit
    reg_write(2, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(5, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write(1, 1'b0, 1'b0, 1'b0, 1'b1);
    simple_request(1'b0, 1'b0, 1'b0, 1'b1);
    check("tp4_idx", last_idx, 1);
    simple_request(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp4_found_after_take", last_found, 0);

    // 5: writes during a scan, held response
    run_request(1'b1, 1'b0, 1'b1, 1'b0, 4, 15, 1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0);
    check("tp5_late_write_seen", last_count, 1);
    check("tp5_late_write_idx", last_idx, 15);
    run_request(1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0);
    check("tp5_early_write_unseen", last_idx, 15);

    // 6: reset mid-scan, then write/take collision
    abort_at(8);
    simple_request(1'b1, 1'b1, 1'b1, 1'b0);
    check("tp6_all_invalid", last_count, 0);
    reg_write(6, 1'b1, 1'b0, 1'b1, 1'b1);
    run_request(1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    check("tp6_collide_idx", last_idx, 6);
    simple_request(1'b1, 1'b1, 1'b1, 1'b0);
    check("tp6_entry_kept", last_found, 1);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        reg_write($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      run_request(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
